// File: rtl/spi_rx_mmio.sv
// Memory-mapped SPI receive peripheral for the picorv32 native bus.
// Received words are buffered in an RX FIFO and exposed with status, control, LED and irq.
module spi_rx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter int          LED_W      = 8,
  parameter int          IRQ_THRESH = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [LED_W-1:0]  led,
  output logic              irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(IRQ_THRESH);

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              en, irq_en, overflow;

  logic        sel, is_write, ne, full;
  logic        pop, push, push_req, ovf_set, ovf_clr, flush, ctrl_wr, led_wr;
  logic [1:0]  offset;
  logic [8:0]  count9;
  logic [31:0] rd_word, led_word;
  logic        unused_addr;

  assign sel      = mem_valid & (mem_addr[31:4] == BASE_ADDR[31:4]) & ~mem_ready;
  assign is_write = |mem_wstrb;
  assign offset   = mem_addr[3:2];
  assign ne       = (count != '0);
  assign full     = (count == FULL_C);
  assign count9   = 9'(count);
  assign unused_addr = &{1'b0, mem_addr[1:0]};

  assign pop      = sel & ~is_write & (offset == 2'd0) & ne;
  assign ctrl_wr  = sel & is_write & (offset == 2'd2) & mem_wstrb[0];
  assign led_wr   = sel & is_write & (offset == 2'd3);
  assign flush    = ctrl_wr & mem_wdata[3];
  assign ovf_clr  = ctrl_wr & mem_wdata[2];
  // A flush swallows a coincident push silently; a pop frees a slot for a push into a full FIFO.
  assign push_req = rx_valid & en;
  assign push     = push_req & ~flush & (~full | pop);
  assign ovf_set  = push_req & ~flush & full & ~pop;

  always_comb begin
    rd_word = '0;
    case (offset)
      2'd0: rd_word = ne ? (32'(fifo_mem[rd_ptr]) | 32'h0001_0000) : 32'h0;
      2'd1: rd_word = {7'b0, count9, 13'b0, overflow, full, ne};
      2'd2: rd_word = {30'b0, irq_en, en};
      2'd3: rd_word = 32'(led);
      default: rd_word = '0;
    endcase
  end

  always_comb begin
    led_word = 32'(led);
    for (int i = 0; i < 4; i++) begin
      if (mem_wstrb[i]) led_word[8*i +: 8] = mem_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      led       <= '0;
      irq       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      en        <= 1'b1;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mem_ready <= sel;
      mem_rdata <= (sel && !is_write) ? rd_word : 32'h0;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end

      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      if (ctrl_wr) begin
        en     <= mem_wdata[0];
        irq_en <= mem_wdata[1];
      end

      if (led_wr) led <= LED_W'(led_word);

      irq <= irq_en & ((count >= THRESH_C) | overflow);
    end
  end

endmodule

// File: tb/tb_spi_rx_mmio.sv
// Directed self-checking bench for spi_rx_mmio with default parameters.
module tb_spi_rx_mmio;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  led;
  logic        irq;

  int compared = 0;
  int mismatched = 0;

  localparam logic [31:0] A_RX   = 32'h0001_0000;
  localparam logic [31:0] A_STAT = 32'h0001_0004;
  localparam logic [31:0] A_CTRL = 32'h0001_0008;
  localparam logic [31:0] A_LED  = 32'h0001_000C;

  spi_rx_mmio dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .led(led), .irq(irq)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Issues one bus access and returns the data seen in the mem_ready cycle.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, output logic [31:0] rdata);
    bit done = 0;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    rdata = '0;
    for (int i = 0; i < 8 && !done; i++) begin
      tick();
      if (mem_ready) begin
        rdata = mem_rdata;
        done = 1;
      end
    end
    mem_valid = 1'b0; mem_wstrb = '0;
    if (!done) begin
      compared++; mismatched++;
      $display("[TB] FAIL bus_timeout addr=%h actual=no_ready required=ready", addr);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = i[0]; mem_addr = A_LED; mem_wdata = 32'hFF; mem_wstrb = 4'hF;
      rx_valid = 1'b1; rx_data = 8'h55;
      tick();
      compared++;
      if (mem_ready !== 1'b0 || led !== 8'h00 || irq !== 1'b0 || mem_rdata !== 32'h0) begin
        mismatched++;
        $display("[TB] FAIL reset_idle actual=rdy%b led%h irq%b rd%h required=rdy0 led00 irq0 rd0",
                 mem_ready, led, irq, mem_rdata);
      end
    end
    mem_valid = 1'b0; mem_wstrb = '0; rx_valid = 1'b0;
    rst_in = 1'b1;
    tick();
    bus(A_STAT, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_status actual=%h required=%h", r, 32'h0); end
    bus(A_CTRL, 0, 4'h0, r);
    compared++;
    if (r !== 32'h1) begin mismatched++; $display("[TB] FAIL reset_ctrl actual=%h required=%h", r, 32'h1); end
  endtask

  task automatic test_drain();
    logic [31:0] r;
    logic [31:0] exp_rx [3] = '{32'h0001_00A5, 32'h0001_003C, 32'h0001_007E};
    push_byte(8'hA5); push_byte(8'h3C); push_byte(8'h7E);
    bus(A_STAT, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0003_0001) begin mismatched++; $display("[TB] FAIL drain_status3 actual=%h required=%h", r, 32'h0003_0001); end
    for (int i = 0; i < 3; i++) begin
      bus(A_RX, 0, 4'h0, r);
      compared++;
      if (r !== exp_rx[i]) begin mismatched++; $display("[TB] FAIL drain_rx%0d actual=%h required=%h", i, r, exp_rx[i]); end
    end
    bus(A_RX, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL drain_empty actual=%h required=%h", r, 32'h0); end
    bus(A_STAT, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL drain_status0 actual=%h required=%h", r, 32'h0); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    for (int i = 0; i <= 16; i++) push_byte(8'(i));
    bus(A_STAT, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0010_0007) begin mismatched++; $display("[TB] FAIL ovf_status actual=%h required=%h", r, 32'h0010_0007); end
    for (int i = 0; i < 16; i++) begin
      bus(A_RX, 0, 4'h0, r);
      compared++;
      if (r !== (32'h0001_0000 | 32'(i))) begin
        mismatched++; $display("[TB] FAIL ovf_drain%0d actual=%h required=%h", i, r, 32'h0001_0000 | 32'(i));
      end
    end
    bus(A_STAT, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0000_0004) begin mismatched++; $display("[TB] FAIL ovf_sticky actual=%h required=%h", r, 32'h4); end
    bus(A_CTRL, 32'h5, 4'h1, r);
    bus(A_STAT, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL ovf_clear actual=%h required=%h", r, 32'h0); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] r;
    logic [31:0] expv;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    mem_valid = 1'b1; mem_addr = A_RX; mem_wstrb = 4'h0;
    rx_data = 8'h99; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; mem_valid = 1'b0;
    r = mem_rdata;
    compared++;
    if (mem_ready !== 1'b1 || r !== 32'h0001_0020) begin
      mismatched++; $display("[TB] FAIL pp_read actual=rdy%b %h required=rdy1 %h", mem_ready, r, 32'h0001_0020);
    end
    bus(A_STAT, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0010_0003) begin mismatched++; $display("[TB] FAIL pp_status actual=%h required=%h", r, 32'h0010_0003); end
    for (int i = 1; i <= 16; i++) begin
      expv = (i == 16) ? 32'h0001_0099 : (32'h0001_0020 + 32'(i));
      bus(A_RX, 0, 4'h0, r);
      compared++;
      if (r !== expv) begin mismatched++; $display("[TB] FAIL pp_drain%0d actual=%h required=%h", i, r, expv); end
    end
  endtask

  task automatic test_irq_flush();
    logic [31:0] r;
    bus(A_CTRL, 32'h3, 4'h1, r);
    tick();
    compared++;
    if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_idle actual=%b required=0", irq); end
    push_byte(8'h42);
    compared++;
    if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL irq_latency actual=%b required=0", irq); end
    tick();
    compared++;
    if (irq !== 1'b1) begin mismatched++; $display("[TB] FAIL irq_set actual=%b required=1", irq); end
    mem_valid = 1'b1; mem_addr = A_CTRL; mem_wdata = 32'hB; mem_wstrb = 4'h1;
    rx_data = 8'h77; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; mem_valid = 1'b0; mem_wstrb = '0;
    bus(A_STAT, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL flush_status actual=%h required=%h", r, 32'h0); end
    compared++;
    if (irq !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_irq actual=%b required=0", irq); end
    bus(A_CTRL, 0, 4'h0, r);
    compared++;
    if (r !== 32'h3) begin mismatched++; $display("[TB] FAIL ctrl_read actual=%h required=%h", r, 32'h3); end
    bus(A_CTRL, 32'h2, 4'h1, r);
    push_byte(8'h11);
    bus(A_STAT, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("[TB] FAIL disabled_push actual=%h required=%h", r, 32'h0); end
    bus(A_CTRL, 32'h1, 4'h1, r);
  endtask

  task automatic test_led();
    logic [31:0] r;
    bus(A_LED, 32'h0000_00F0, 4'b0001, r);
    compared++;
    if (led !== 8'hF0) begin mismatched++; $display("[TB] FAIL led_lane0 actual=%h required=%h", led, 8'hF0); end
    bus(A_LED, 32'h0000_0011, 4'b0010, r);
    compared++;
    if (led !== 8'hF0) begin mismatched++; $display("[TB] FAIL led_lane1 actual=%h required=%h", led, 8'hF0); end
    bus(A_LED, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0000_00F0) begin mismatched++; $display("[TB] FAIL led_read actual=%h required=%h", r, 32'hF0); end
    tick();
    compared++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
      mismatched++; $display("[TB] FAIL ready_pulse actual=rdy%b rd%h required=rdy0 rd0", mem_ready, mem_rdata);
    end
    bus(A_LED, 32'hFFFF_FF5A, 4'hF, r);
    bus(A_LED, 0, 4'h0, r);
    compared++;
    if (r !== 32'h0000_005A) begin mismatched++; $display("[TB] FAIL led_full actual=%h required=%h", r, 32'h5A); end
  endtask

  task automatic test_unselected();
    mem_valid = 1'b1; mem_addr = 32'h0002_0004; mem_wstrb = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (mem_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL unselected actual=%b required=0", mem_ready); end
    end
    mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    push_byte(8'hC1); push_byte(8'hC2);
    mem_valid = 1'b1; mem_addr = A_RX; mem_wstrb = 4'h0;
    tick();
    compared++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'h0001_00C1) begin
      mismatched++; $display("[TB] FAIL b2b_first actual=rdy%b %h required=rdy1 %h", mem_ready, mem_rdata, 32'h0001_00C1);
    end
    tick();
    compared++;
    if (mem_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_gap actual=%b required=0", mem_ready); end
    tick();
    compared++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'h0001_00C2) begin
      mismatched++; $display("[TB] FAIL b2b_second actual=rdy%b %h required=rdy1 %h", mem_ready, mem_rdata, 32'h0001_00C2);
    end
    mem_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_drain();
    test_overflow();
    test_push_pop_full();
    test_irq_flush();
    test_led();
    test_unselected();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
